// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage forwarding, stall and MDU register scoreboard with stall statistics
module hazard_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int MDU_SLOTS = 2,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W = 32,
  localparam int AW = $clog2(NREG),
  localparam int BW = $clog2(MDU_SLOTS + 1)
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic [AW-1:0]   rR1_ID,
  input  logic [AW-1:0]   rR2_ID,
  input  logic            read_rD1,
  input  logic            read_rD2,
  input  logic [AW-1:0]   wR_ID,
  input  logic            rf_we_ID,
  input  logic            mdu_op_ID,
  input  logic            flush_ID,
  input  logic [AW-1:0]   wR_EX,
  input  logic [AW-1:0]   wR_MEM,
  input  logic [AW-1:0]   wR_WB,
  input  logic            rf_we_EX,
  input  logic            rf_we_MEM,
  input  logic            rf_we_WB,
  input  logic [XLEN-1:0] wD_EX,
  input  logic [XLEN-1:0] wD_MEM,
  input  logic [XLEN-1:0] wD_WB,
  input  logic            wD_vld_EX,
  input  logic            wD_vld_MEM,
  input  logic            mdu_done,
  input  logic [AW-1:0]   mdu_wR,
  input  logic [XLEN-1:0] mdu_wD,
  output logic            forward_op1,
  output logic            forward_op2,
  output logic [XLEN-1:0] rD1_forward,
  output logic [XLEN-1:0] rD2_forward,
  output logic            pipeline_stop_PC,
  output logic            pipeline_stop_REG_IF_ID,
  output logic            flush_REG_ID_EX,
  output logic            mdu_issue,
  output logic [BW-1:0]   mdu_busy_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic            hazard_timeout
);
  localparam int TW = $clog2(STALL_TIMEOUT + 1);
  logic [NREG-1:0] busy, busy_eff, done_mask, issue_mask;
  logic [AW-1:0]   rr [2];
  logic            rd [2];
  logic [3:0]      hit [2];
  logic [XLEN-1:0] fwd_data [2];
  logic            not_rdy [2];
  logic            hazard [2];
  logic            stall;
  logic [TW-1:0]   consec;
  always_comb begin
    done_mask = '0;
    if (mdu_done && mdu_wR != '0) done_mask[mdu_wR] = 1'b1;
    busy_eff = busy & ~done_mask;
    rr[0] = rR1_ID;
    rr[1] = rR2_ID;
    rd[0] = read_rD1;
    rd[1] = read_rD2;
    for (int i = 0; i < 2; i++) begin
      // hit bits in priority order: [0]=MDU, [1]=EX, [2]=MEM, [3]=WB
      hit[i] = rr[i] == '0 ? 4'b0 : {rf_we_WB && wR_WB == rr[i], rf_we_MEM && wR_MEM == rr[i],
                                     rf_we_EX && wR_EX == rr[i], mdu_done && mdu_wR == rr[i]};
      fwd_data[i] = hit[i][0] ? mdu_wD : hit[i][1] ? wD_EX : hit[i][2] ? wD_MEM : hit[i][3] ? wD_WB : '0;
      not_rdy[i] = !hit[i][0] && (hit[i][1] ? !wD_vld_EX : hit[i][2] && !wD_vld_MEM);
      hazard[i] = rd[i] && (not_rdy[i] || busy_eff[rr[i]]);
    end
    stall = !flush_ID && (hazard[0] || hazard[1] || (rf_we_ID && busy_eff[wR_ID]) ||
                          (mdu_op_ID && mdu_busy_cnt == BW'(MDU_SLOTS) && !mdu_done));
    mdu_issue = mdu_op_ID && !stall && !flush_ID;
    issue_mask = '0;
    if (mdu_issue && wR_ID != '0) issue_mask[wR_ID] = 1'b1;
    forward_op1 = |hit[0] && read_rD1;
    forward_op2 = |hit[1] && read_rD2;
    rD1_forward = fwd_data[0];
    rD2_forward = fwd_data[1];
    pipeline_stop_PC = stall;
    pipeline_stop_REG_IF_ID = stall;
    flush_REG_ID_EX = stall;
  end
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      busy <= '0;
      mdu_busy_cnt <= '0;
      stall_cnt <= '0;
      consec <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      busy <= busy_eff | issue_mask;
      mdu_busy_cnt <= mdu_busy_cnt + BW'(mdu_issue) - BW'(mdu_done && busy[mdu_wR]);
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      consec <= !stall ? '0 : consec == TW'(STALL_TIMEOUT) ? consec : consec + TW'(1);
      hazard_timeout <= hazard_timeout || (stall && consec == TW'(STALL_TIMEOUT - 1));
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: model-driven scoreboard bench plus directed checks for hazard_scoreboard
module tb_hazard_scoreboard;
  logic cpu_clk, cpu_rst;
  logic [4:0] rR1_ID, rR2_ID, wR_ID, wR_EX, wR_MEM, wR_WB, mdu_wR;
  logic read_rD1, read_rD2, rf_we_ID, mdu_op_ID, flush_ID;
  logic rf_we_EX, rf_we_MEM, rf_we_WB, wD_vld_EX, wD_vld_MEM, mdu_done;
  logic [31:0] wD_EX, wD_MEM, wD_WB, mdu_wD;
  logic forward_op1, forward_op2, pipeline_stop_PC, pipeline_stop_REG_IF_ID, flush_REG_ID_EX, mdu_issue;
  logic [31:0] rD1_forward, rD2_forward, stall_cnt;
  logic [1:0] mdu_busy_cnt;
  logic hazard_timeout;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic f1, f2, st, iss, to;
    logic [31:0] d1, d2, sc;
    logic [1:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] mbusy, msc;
  int mcnt, mcon;
  logic mto;

  hazard_scoreboard #(.STALL_TIMEOUT(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .rR1_ID(rR1_ID), .rR2_ID(rR2_ID),
    .read_rD1(read_rD1), .read_rD2(read_rD2), .wR_ID(wR_ID), .rf_we_ID(rf_we_ID),
    .mdu_op_ID(mdu_op_ID), .flush_ID(flush_ID), .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
    .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM), .rf_we_WB(rf_we_WB), .wD_EX(wD_EX),
    .wD_MEM(wD_MEM), .wD_WB(wD_WB), .wD_vld_EX(wD_vld_EX), .wD_vld_MEM(wD_vld_MEM),
    .mdu_done(mdu_done), .mdu_wR(mdu_wR), .mdu_wD(mdu_wD), .forward_op1(forward_op1),
    .forward_op2(forward_op2), .rD1_forward(rD1_forward), .rD2_forward(rD2_forward),
    .pipeline_stop_PC(pipeline_stop_PC), .pipeline_stop_REG_IF_ID(pipeline_stop_REG_IF_ID),
    .flush_REG_ID_EX(flush_REG_ID_EX), .mdu_issue(mdu_issue), .mdu_busy_cnt(mdu_busy_cnt),
    .stall_cnt(stall_cnt), .hazard_timeout(hazard_timeout)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic idle();
    {rR1_ID, rR2_ID, wR_ID, wR_EX, wR_MEM, wR_WB, mdu_wR} = '0;
    {read_rD1, read_rD2, rf_we_ID, mdu_op_ID, flush_ID, rf_we_EX, rf_we_MEM, rf_we_WB} = '0;
    {wD_vld_EX, wD_vld_MEM, mdu_done} = 3'b111;
    mdu_done = 1'b0;
    {wD_EX, wD_MEM, wD_WB, mdu_wD} = '0;
  endtask

  task automatic model_reset();
    mbusy = '0; msc = '0; mcnt = 0; mcon = 0; mto = 1'b0;
  endtask

  // Predict this cycle's outputs, compare them, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    logic [31:0] beff, bold, d[2];
    logic [4:0] r[2];
    logic rd[2], h[2], nr[2], st;
    r[0] = rR1_ID; r[1] = rR2_ID; rd[0] = read_rD1; rd[1] = read_rD2;
    beff = mbusy;
    if (mdu_done && mdu_wR != 0) beff[mdu_wR] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      h[i] = 0; nr[i] = 0; d[i] = 0;
      if (r[i] != 0) begin
        if (mdu_done && mdu_wR == r[i]) begin h[i] = 1; d[i] = mdu_wD; end
        else if (rf_we_EX && wR_EX == r[i]) begin h[i] = 1; d[i] = wD_EX; nr[i] = !wD_vld_EX; end
        else if (rf_we_MEM && wR_MEM == r[i]) begin h[i] = 1; d[i] = wD_MEM; nr[i] = !wD_vld_MEM; end
        else if (rf_we_WB && wR_WB == r[i]) begin h[i] = 1; d[i] = wD_WB; end
      end
    end
    st = !flush_ID && ((rd[0] && (nr[0] || beff[r[0]])) || (rd[1] && (nr[1] || beff[r[1]])) ||
                       (rf_we_ID && beff[wR_ID]) || (mdu_op_ID && mcnt == 2 && !mdu_done));
    e.f1 = h[0] && rd[0]; e.f2 = h[1] && rd[1]; e.d1 = d[0]; e.d2 = d[1];
    e.st = st; e.iss = mdu_op_ID && !st && !flush_ID;
    e.cnt = 2'(mcnt); e.sc = msc; e.to = mto;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    chk("fwd1", forward_op1, e.f1);
    chk("fwd2", forward_op2, e.f2);
    chk("rd1", rD1_forward, e.d1);
    chk("rd2", rD2_forward, e.d2);
    chk("stop_pc", pipeline_stop_PC, e.st);
    chk("stop_ifid", pipeline_stop_REG_IF_ID, e.st);
    chk("flush_idex", flush_REG_ID_EX, e.st);
    chk("issue", mdu_issue, e.iss);
    chk("busy_cnt", mdu_busy_cnt, e.cnt);
    chk("stall_cnt", stall_cnt, e.sc);
    chk("timeout", hazard_timeout, e.to);
    @(posedge cpu_clk);
    if (cpu_rst) model_reset();
    else begin
      bold = mbusy;
      mbusy = beff;
      if (e.iss && wR_ID != 0) mbusy[wR_ID] = 1'b1;
      mcnt = mcnt + int'(e.iss) - int'(mdu_done && bold[mdu_wR]);
      if (st) begin
        if (msc != '1) msc++;
        mcon = mcon < 8 ? mcon + 1 : 8;
        if (mcon == 8) mto = 1'b1;
      end else mcon = 0;
    end
    #1;
  endtask

  task automatic issue_mdu(input logic [4:0] r);
    idle(); mdu_op_ID = 1; wR_ID = r; step();
  endtask

  initial begin
    idle();
    cpu_rst = 1;
    @(posedge cpu_clk); #1;
    cpu_rst = 0;
    model_reset();
    chk("rst_cnt", mdu_busy_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_timeout", hazard_timeout, 0);
    idle(); step();
    // EX has priority over MEM for x5
    rf_we_EX = 1; wR_EX = 5; wD_EX = 32'h11; rf_we_MEM = 1; wR_MEM = 5; wD_MEM = 32'h22;
    rR1_ID = 5; read_rD1 = 1; step();
    chk("tp1_data", rD1_forward, 32'h11);
    chk("tp1_nostall", pipeline_stop_PC, 0);
    // x0 never forwards
    idle(); rf_we_EX = 1; wR_EX = 0; wD_EX = 32'h99; read_rD1 = 1; step();
    chk("x0_nofwd", forward_op1, 0);
    // load-use: EX not ready, then MEM ready
    idle(); rf_we_EX = 1; wR_EX = 6; wD_vld_EX = 0; rR2_ID = 6; read_rD2 = 1; step();
    idle(); rf_we_MEM = 1; wR_MEM = 6; wD_MEM = 32'h33; rR2_ID = 6; read_rD2 = 1; step();
    chk("tp2_data", rD2_forward, 32'h33);
    chk("tp2_nostall", pipeline_stop_PC, 0);
    // MDU op to x7 and a dependent reader
    issue_mdu(7);
    chk("tp3_cnt1", mdu_busy_cnt, 1);
    idle(); rR1_ID = 7; read_rD1 = 1; step(); step();
    chk("tp3_stall", pipeline_stop_PC, 1);
    mdu_done = 1; mdu_wR = 7; mdu_wD = 32'h44; step();
    chk("tp3_data", rD1_forward, 32'h44);
    chk("tp3_cnt0", mdu_busy_cnt, 0);
    // structural: two outstanding, third waits until a completion
    issue_mdu(9); issue_mdu(10);
    issue_mdu(11);
    chk("tp4_struct", pipeline_stop_PC, 1);
    mdu_done = 1; mdu_wR = 9; mdu_wD = 32'h55; step();
    chk("tp4_cnt", mdu_busy_cnt, 2);
    idle(); mdu_done = 1; mdu_wR = 10; step();
    idle(); mdu_done = 1; mdu_wR = 11; step();
    chk("tp4_drain", mdu_busy_cnt, 0);
    // WAW on busy x8, with a flush in the middle
    issue_mdu(8);
    idle(); rf_we_ID = 1; wR_ID = 8; step(); step();
    chk("waw_stall", pipeline_stop_PC, 1);
    flush_ID = 1; step();
    chk("waw_flush", pipeline_stop_PC, 0);
    chk("waw_flush_cnt", mdu_busy_cnt, 1);
    flush_ID = 0; step();
    mdu_done = 1; mdu_wR = 8; step();
    idle(); step();
    // random mix against the model
    for (int n = 0; n < 80; n++) begin
      idle();
      rR1_ID = 5'($urandom_range(0, 7)); rR2_ID = 5'($urandom_range(0, 7));
      read_rD1 = 1'($urandom); read_rD2 = 1'($urandom);
      wR_ID = 5'($urandom_range(1, 7)); rf_we_ID = 1'($urandom);
      mdu_op_ID = $urandom_range(0, 3) == 0; flush_ID = $urandom_range(0, 7) == 0;
      wR_EX = 5'($urandom_range(0, 7)); wR_MEM = 5'($urandom_range(0, 7)); wR_WB = 5'($urandom_range(0, 7));
      rf_we_EX = 1'($urandom); rf_we_MEM = 1'($urandom); rf_we_WB = 1'($urandom);
      wD_vld_EX = 1'($urandom); wD_vld_MEM = 1'($urandom);
      wD_EX = $urandom; wD_MEM = $urandom; wD_WB = $urandom; mdu_wD = $urandom;
      mdu_done = $urandom_range(0, 2) == 0; mdu_wR = 5'($urandom_range(1, 7));
      step();
    end
    // watchdog: reset, then hold a dependency for 8 cycles
    idle(); cpu_rst = 1; step(); cpu_rst = 0;
    issue_mdu(12);
    idle(); rR1_ID = 12; read_rD1 = 1;
    repeat (7) step();
    chk("wd_before", hazard_timeout, 0);
    step();
    chk("wd_trip", hazard_timeout, 1);
    chk("wd_stall_cnt", stall_cnt, 8);
    step();
    chk("wd_sticky", hazard_timeout, 1);
    idle(); cpu_rst = 1; step(); cpu_rst = 0;
    chk("rst2_cnt", mdu_busy_cnt, 0);
    chk("rst2_timeout", hazard_timeout, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    idle(); mdu_done = 1; mdu_wR = 12; mdu_wD = 32'h77; step();
    chk("stale_done", mdu_busy_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
